// File: rtl/pipe_sel_mux.sv
// Registered N-way operand select stage with valid/ready flow control.
// A 2-entry store (main + skid) keeps in_ready a pure function of state.
// A select at or beyond n_in yields an all-zero word tagged with an error bit.
module pipe_sel_mux #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 3,
  parameter int SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_sel_err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  // State is the (main valid, skid valid) pair.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL1 = 2'b10,
    ST_FULL2 = 2'b11
  } state_t;

  state_t             state_r;
  state_t             state_nx_s;
  logic [WIDTH-1:0]   main_data_r;
  logic               main_err_r;
  logic [WIDTH-1:0]   skid_data_r;
  logic               skid_err_r;
  logic [WIDTH-1:0]   sel_word_s;
  logic               sel_err_s;
  logic               accept_s;
  logic               pop_s;
  logic               load_main_s;
  logic               load_skid_s;
  logic               main_from_skid_s;

  // Both flow-control outputs decode straight from the state register.
  assign in_ready    = (state_r != ST_FULL2);
  assign out_valid   = (state_r != ST_EMPTY);
  assign out_data    = main_data_r;
  assign out_sel_err = main_err_r;

  assign accept_s = in_valid & in_ready;
  assign pop_s    = out_valid & out_ready;

  // Pick the addressed input word; out-of-range selects give zero plus error.
  always_comb begin
    sel_word_s = {WIDTH{1'b0}};
    sel_err_s  = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_word_s = in_bus[k*WIDTH +: WIDTH];
        sel_err_s  = 1'b0;
      end else begin
        sel_word_s = sel_word_s;
        sel_err_s  = sel_err_s;
      end
    end
  end

  // Next-state and load enables; flush squashes both entries and any accept.
  always_comb begin
    state_nx_s       = state_r;
    load_main_s      = 1'b0;
    load_skid_s      = 1'b0;
    main_from_skid_s = 1'b0;
    if (flush) begin
      state_nx_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_nx_s  = ST_FULL1;
            load_main_s = 1'b1;
          end else begin
            state_nx_s = ST_EMPTY;
          end
        end
        ST_FULL1: begin
          if (accept_s && pop_s) begin
            state_nx_s  = ST_FULL1;
            load_main_s = 1'b1;
          end else if (accept_s) begin
            state_nx_s  = ST_FULL2;
            load_skid_s = 1'b1;
          end else if (pop_s) begin
            state_nx_s = ST_EMPTY;
          end else begin
            state_nx_s = ST_FULL1;
          end
        end
        ST_FULL2: begin
          if (pop_s) begin
            state_nx_s       = ST_FULL1;
            main_from_skid_s = 1'b1;
          end else begin
            state_nx_s = ST_FULL2;
          end
        end
        default: begin
          state_nx_s = ST_EMPTY;
        end
      endcase
    end
  end

  // State register; reset has top priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Main entry: loads only on an accept or a skid transfer, otherwise holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_data_r <= {WIDTH{1'b0}};
      main_err_r  <= 1'b0;
    end else if (load_main_s) begin
      main_data_r <= sel_word_s;
      main_err_r  <= sel_err_s;
    end else if (main_from_skid_s) begin
      main_data_r <= skid_data_r;
      main_err_r  <= skid_err_r;
    end else begin
      main_data_r <= main_data_r;
      main_err_r  <= main_err_r;
    end
  end

  // Skid entry: catches the word accepted while the head is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_data_r <= {WIDTH{1'b0}};
      skid_err_r  <= 1'b0;
    end else if (load_skid_s) begin
      skid_data_r <= sel_word_s;
      skid_err_r  <= sel_err_s;
    end else begin
      skid_data_r <= skid_data_r;
      skid_err_r  <= skid_err_r;
    end
  end

endmodule

// File: tb/tb_pipe_sel_mux.sv
// Self-checking bench for pipe_sel_mux: directed scenarios plus a random soak
// compared against a queue-based model of the two-entry stage.
module tb_pipe_sel_mux;

  localparam int WIDTH = 32;
  localparam int N_IN  = 3;
  localparam int SEL_W = 2;

  logic                  clk;
  logic                  reset;
  logic [N_IN*WIDTH-1:0] in_bus;
  logic [SEL_W-1:0]      sel;
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic [WIDTH-1:0]      out_data;
  logic                  out_sel_err;
  logic                  out_valid;
  logic                  out_ready;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] data;
  } ent_t;

  ent_t             m_q[$];
  logic [WIDTH-1:0] m_shown_data = '0;
  logic             m_shown_err  = 1'b0;

  pipe_sel_mux #(.WIDTH(WIDTH), .N_IN(N_IN), .SEL_W(SEL_W)) dut (
    .clk(clk), .reset(reset), .in_bus(in_bus), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .out_sel_err(out_sel_err), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: FIFO of capacity two; the head is what the stage shows.
  task automatic model_step();
    bit   acc;
    bit   pop;
    ent_t e;
    acc = in_valid && (m_q.size() < 2);
    pop = (m_q.size() > 0) && out_ready;
    if (int'(sel) < N_IN) begin
      e.data = WIDTH'(in_bus >> (int'(sel) * WIDTH));
      e.err  = 1'b0;
    end else begin
      e.data = '0;
      e.err  = 1'b1;
    end
    if (reset) begin
      m_q.delete();
      m_shown_data = '0;
      m_shown_err  = 1'b0;
    end else if (flush) begin
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (acc) m_q.push_back(e);
    end
    if (m_q.size() > 0) begin
      m_shown_data = m_q[0].data;
      m_shown_err  = m_q[0].err;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    sel = '0; in_bus = '0;
    tick();
    reset = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h expected 0", out_data); end
    n_cmp++; if (out_sel_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", out_sel_err); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_streaming();
    logic [WIDTH-1:0] exp_w [3];
    exp_w[0] = 32'hA; exp_w[1] = 32'hB; exp_w[2] = 32'hC;
    out_ready = 1'b1;
    in_bus = {32'hC, 32'hB, 32'hA};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; sel = SEL_W'(i);
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, out_valid); end
      n_cmp++; if (out_data !== exp_w[i]) begin n_err++; $display("FAIL stream_data[%0d]: got %h expected %h", i, out_data, exp_w[i]); end
      n_cmp++; if (out_sel_err !== 1'b0) begin n_err++; $display("FAIL stream_err[%0d]: got %b expected 0", i, out_sel_err); end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain: got %b expected 0", out_valid); end
    n_cmp++; if (out_data !== 32'hC) begin n_err++; $display("FAIL stream_keep: got %h expected c", out_data); end
  endtask

  task automatic test_invalid_sel();
    out_ready = 1'b1;
    in_bus = {32'hC, 32'hB, 32'hA};
    in_valid = 1'b1; sel = 2'd3;
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL badsel_valid: got %b expected 1", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL badsel_data: got %h expected 0", out_data); end
    n_cmp++; if (out_sel_err !== 1'b1) begin n_err++; $display("FAIL badsel_err: got %b expected 1", out_sel_err); end
    sel = 2'd1;
    tick();
    n_cmp++; if (out_data !== 32'hB) begin n_err++; $display("FAIL badsel_next_data: got %h expected b", out_data); end
    n_cmp++; if (out_sel_err !== 1'b0) begin n_err++; $display("FAIL badsel_next_err: got %b expected 0", out_sel_err); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_pressure();
    logic [WIDTH-1:0] w [3];
    w[0] = 32'h1111_0000; w[1] = 32'h2222_0001; w[2] = 32'h3333_0002;
    out_ready = 1'b0; sel = 2'd0; in_bus = '0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_bus[WIDTH-1:0] = w[i];
      tick();
    end
    // W0 in main, W1 in skid, W2 still offered upstream.
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_low: got %b expected 0", in_ready); end
    n_cmp++; if (out_data !== w[0]) begin n_err++; $display("FAIL bp_hold: got %h expected %h", out_data, w[0]); end
    tick();
    n_cmp++; if (out_data !== w[0]) begin n_err++; $display("FAIL bp_hold2: got %h expected %h", out_data, w[0]); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_data !== w[1]) begin n_err++; $display("FAIL bp_out1: got %h expected %h", out_data, w[1]); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back: got %b expected 1", in_ready); end
    tick();
    n_cmp++; if (out_data !== w[2]) begin n_err++; $display("FAIL bp_out2: got %h expected %h", out_data, w[2]); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out2_valid: got %b expected 1", out_valid); end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0; sel = 2'd2; in_bus = '0;
    in_valid = 1'b1; in_bus[2*WIDTH +: WIDTH] = 32'h7777_7777;
    tick();
    in_bus[2*WIDTH +: WIDTH] = 32'h8888_8888;
    tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_full2: got %b expected 0", in_ready); end
    flush = 1'b1; in_bus[2*WIDTH +: WIDTH] = 32'h9999_9999;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b expected 1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0 || out_data === 32'h9999_9999) begin n_err++; $display("FAIL flush_leak: got valid %b data %h expected idle without 99999999", out_valid, out_data); end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; sel = 2'd0; in_bus = '0;
    in_valid = 1'b1; in_bus[WIDTH-1:0] = 32'hDEADBEEF;
    tick();
    n_cmp++; if (out_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL rst_mid_pre: got %h expected deadbeef", out_data); end
    reset = 1'b1; in_valid = 1'b0;
    tick();
    reset = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL rst_mid_data: got %h expected 0", out_data); end
    n_cmp++; if (out_sel_err !== 1'b0) begin n_err++; $display("FAIL rst_mid_err: got %b expected 0", out_sel_err); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_random_soak();
    bit               hold;
    logic [WIDTH-1:0] prev_data;
    logic             prev_err;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      sel       = SEL_W'($urandom_range(0, 3));
      for (int k = 0; k < N_IN; k++) in_bus[k*WIDTH +: WIDTH] = $urandom;
      hold      = out_valid && !out_ready && !flush;
      prev_data = out_data;
      prev_err  = out_sel_err;
      tick();
      n_cmp++; if (out_valid !== (m_q.size() > 0)) begin n_err++; $display("FAIL soak_valid @%0d: got %b expected %b", c, out_valid, m_q.size() > 0); end
      n_cmp++; if (in_ready !== (m_q.size() < 2)) begin n_err++; $display("FAIL soak_ready @%0d: got %b expected %b", c, in_ready, m_q.size() < 2); end
      n_cmp++; if (out_data !== m_shown_data) begin n_err++; $display("FAIL soak_data @%0d: got %h expected %h", c, out_data, m_shown_data); end
      n_cmp++; if (out_sel_err !== m_shown_err) begin n_err++; $display("FAIL soak_err @%0d: got %b expected %b", c, out_sel_err, m_shown_err); end
      if (hold) begin
        n_cmp++; if (out_data !== prev_data || out_sel_err !== prev_err) begin n_err++; $display("FAIL soak_hold @%0d: got %h/%b expected %h/%b", c, out_data, out_sel_err, prev_data, prev_err); end
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_invalid_sel();
    test_back_pressure();
    test_flush_full();
    test_reset_mid();
    test_random_soak();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
